serial_out_tx: RTL and testbench

Memory-mapped UART transmitter for the single-cycle MIPS core. It drives the board's `UART_TXD` pin and is the serial counterpart of the parallel output port. It decodes CPU store cycles on the data-memory bus, queues bytes in a 4-entry FIFO and serialises each one as an 8N1 frame. It also exposes a status byte that is muxed into the load path the same way the parallel input port is.

---
 rtl/serial_out_tx.sv | 151 +++++++++++++++
 tb/tb_serial_out_tx.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_out_tx.sv
// serial_out_tx: memory-mapped 8N1 UART transmitter for the single-cycle MIPS core.
// A store to DATA_ADDR queues a byte in a 4-entry FIFO. A transmit FSM then sends
// each byte LSB first: one start bit, eight data bits and one stop bit.
// A store to STATUS_ADDR clears the sticky overflow flag.
//
// Ports:
//   clk      core clock; all state changes on its rising edge
//   rst      synchronous active-high reset
//   Address  data-memory address (ALU result)
//   RegData  store data; bits [7:0] are enqueued
//   we       MemWrite strobe
//   tx       serial line, idle high, driven straight from a flop
//   status   {4'b0, overflow, busy, full, empty}, combinational view of registers
//   sel      high when Address hits DATA_ADDR or STATUS_ADDR (load-mux select)
module serial_out_tx #(
  parameter int         CLKS_PER_BIT = 87,
  parameter logic [7:0] DATA_ADDR    = 8'hFD,
  parameter logic [7:0] STATUS_ADDR  = 8'hFC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] Address,
  input  logic [7:0] RegData,
  input  logic       we,
  output logic       tx,
  output logic [7:0] status,
  output logic       sel
);

  localparam logic [7:0] LAST_TICK = 8'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t     r_state;
  logic [7:0] r_mem [4];
  logic [1:0] r_wptr, r_rptr;
  logic [2:0] r_count;
  logic       r_overflow;
  logic [7:0] r_shift;
  logic [2:0] r_bitcnt;
  logic [7:0] r_baud;
  logic       r_tx;

  logic       w_empty, w_full;
  logic       w_wr_data, w_wr_stat;
  logic       w_pop, w_push;
  logic       w_tick;

  assign w_empty   = (r_count == 3'd0);
  assign w_full    = (r_count == 3'd4);
  assign w_wr_data = we && (Address == DATA_ADDR);
  assign w_wr_stat = we && (Address == STATUS_ADDR);
  // The FSM pops the head byte only from IDLE.
  assign w_pop     = (r_state == S_IDLE) && !w_empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign w_push    = w_wr_data && (!w_full || w_pop);
  assign w_tick    = (r_baud == LAST_TICK);

  // FIFO storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= RegData;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr     <= 2'd0;
      r_rptr     <= 2'd0;
      r_count    <= 3'd0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 2'd1;
      if (w_pop)  r_rptr <= r_rptr + 2'd1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
      // A clear beats a same-cycle drop.
      if (w_wr_stat)
        r_overflow <= 1'b0;
      else if (w_wr_data && w_full && !w_pop)
        r_overflow <= 1'b1;
    end
  end

  // Transmit FSM. tx is registered and set up one edge ahead of each bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_tx     <= 1'b1;
      r_shift  <= 8'd0;
      r_bitcnt <= 3'd0;
      r_baud   <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_shift  <= r_mem[r_rptr];
            r_bitcnt <= 3'd0;
            r_baud   <= 8'd0;
            r_tx     <= 1'b0;
            r_state  <= S_START;
          end
        end
        S_START: begin
          if (w_tick) begin
            r_baud  <= 8'd0;
            r_tx    <= r_shift[0];
            r_state <= S_DATA;
          end else begin
            r_baud <= r_baud + 8'd1;
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_baud <= 8'd0;
            if (r_bitcnt == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              // Next bit is shift[1], which becomes bit 0 after the shift.
              r_shift  <= {1'b0, r_shift[7:1]};
              r_tx     <= r_shift[1];
              r_bitcnt <= r_bitcnt + 3'd1;
            end
          end else begin
            r_baud <= r_baud + 8'd1;
          end
        end
        S_STOP: begin
          if (w_tick) begin
            r_baud  <= 8'd0;
            r_state <= S_IDLE;
          end else begin
            r_baud <= r_baud + 8'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

  assign tx     = r_tx;
  assign status = {4'b0000, r_overflow, (r_state != S_IDLE), w_full, w_empty};
  assign sel    = (Address == DATA_ADDR) || (Address == STATUS_ADDR);

endmodule

// File: tb/tb_serial_out_tx.sv
// Directed bench for serial_out_tx with CLKS_PER_BIT = 4.
// A background receiver decodes the tx line into a byte queue and records each start time.
module tb_serial_out_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       we = 1'b0;
  logic [7:0] Address = 8'h00;
  logic [7:0] RegData = 8'h00;
  logic       tx;
  logic [7:0] status;
  logic       sel;

  serial_out_tx #(.CLKS_PER_BIT(4), .DATA_ADDR(8'hFD), .STATUS_ADDR(8'hFC)) dut (
    .clk(clk), .rst(rst), .Address(Address), .RegData(RegData), .we(we),
    .tx(tx), .status(status), .sel(sel)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Line receiver. Sampling happens on negedges. Count 0 is the first low sample.
  // Data bit k is sampled at count 4k+5. The stop bit is sampled at count 37.
  logic [7:0] rx_q [$];
  int         rx_t [$];
  int         rx_ferr = 0;
  bit         rx_busy = 1'b0;
  int         rx_cnt  = 0;
  logic [7:0] rx_sh   = 8'h00;

  always @(negedge clk) begin
    if (rst) begin
      rx_busy <= 1'b0;
    end else if (!rx_busy) begin
      if (tx === 1'b0) begin
        rx_busy <= 1'b1;
        rx_cnt  <= 1;
        rx_t.push_back(cyc);
      end
    end else begin
      rx_cnt <= rx_cnt + 1;
      if (rx_cnt >= 5 && rx_cnt <= 33 && ((rx_cnt - 5) % 4) == 0)
        rx_sh[(rx_cnt - 5) / 4] <= tx;
      if (rx_cnt == 37) begin
        if (tx !== 1'b1) rx_ferr <= rx_ferr + 1;
        rx_q.push_back(rx_sh);
        rx_busy <= 1'b0;
      end
    end
  end

  // The store is registered at the posedge between the entry and exit negedges.
  task automatic do_store(input logic [7:0] a, input logic [7:0] d);
    we = 1'b1; Address = a; RegData = d;
    @(negedge clk);
    we = 1'b0; Address = 8'h00; RegData = 8'h00;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle_cycles(2);
    rst = 1'b0;
    @(negedge clk);
    tests++; if (tx !== 1'b1) begin fails++; $display("FAIL reset_tx got %b want 1", tx); end
    tests++; if (status !== 8'h01) begin fails++; $display("FAIL reset_status got %h want 01", status); end
    tests++; if (sel !== 1'b0) begin fails++; $display("FAIL reset_sel00 got %b want 0", sel); end
    Address = 8'hFD; #1;
    tests++; if (sel !== 1'b1) begin fails++; $display("FAIL sel_fd got %b want 1", sel); end
    Address = 8'hFC; #1;
    tests++; if (sel !== 1'b1) begin fails++; $display("FAIL sel_fc got %b want 1", sel); end
    Address = 8'hFE; #1;
    tests++; if (sel !== 1'b0) begin fails++; $display("FAIL sel_fe got %b want 0", sel); end
    Address = 8'h00;
  endtask

  task automatic test_ignore;
    rx_q.delete(); rx_t.delete();
    do_store(8'h80, 8'h5A);
    // A matching address with we low must also be ignored.
    Address = 8'hFD; RegData = 8'h33; @(negedge clk); Address = 8'h00;
    idle_cycles(50);
    tests++; if (status !== 8'h01) begin fails++; $display("FAIL ignore_status got %h want 01", status); end
    tests++; if (rx_q.size() != 0) begin fails++; $display("FAIL ignore_frames got %0d want 0", rx_q.size()); end
  endtask

  task automatic test_single;
    logic [7:0] b;
    logic       e;
    b = 8'hA5;
    rx_q.delete(); rx_t.delete();
    do_store(8'hFD, b);
    tests++; if (tx !== 1'b1) begin fails++; $display("FAIL single_pre_tx got %b want 1", tx); end
    tests++; if (status !== 8'h00) begin fails++; $display("FAIL single_pre_status got %h want 00", status); end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i < 4) e = 1'b0;
      else if (i < 36) e = b[(i - 4) / 4];
      else e = 1'b1;
      tests++; if (tx !== e) begin fails++; $display("FAIL single_tx cycle %0d got %b want %b", i, tx, e); end
      tests++; if (status[2] !== 1'b1) begin fails++; $display("FAIL single_busy cycle %0d got %b want 1", i, status[2]); end
    end
    @(negedge clk);
    tests++; if (tx !== 1'b1) begin fails++; $display("FAIL single_post_tx got %b want 1", tx); end
    tests++; if (status !== 8'h01) begin fails++; $display("FAIL single_post_status got %h want 01", status); end
    idle_cycles(5);
    tests++; if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin fails++; $display("FAIL single_rx got n=%0d want A5", rx_q.size()); end
  endtask

  task automatic test_back_to_back;
    int n;
    rx_q.delete(); rx_t.delete();
    do_store(8'hFD, 8'h00);
    do_store(8'hFD, 8'hFF);
    idle_cycles(10);
    tests++; if (status !== 8'h04) begin fails++; $display("FAIL b2b_mid_status got %h want 04", status); end
    n = 0;
    while (rx_q.size() < 2 && n < 150) begin @(negedge clk); n++; end
    tests++; if (rx_q.size() != 2) begin fails++; $display("FAIL b2b_count got %0d want 2", rx_q.size()); end
    else begin
      tests++; if (rx_q[0] !== 8'h00) begin fails++; $display("FAIL b2b_byte0 got %h want 00", rx_q[0]); end
      tests++; if (rx_q[1] !== 8'hFF) begin fails++; $display("FAIL b2b_byte1 got %h want FF", rx_q[1]); end
      tests++; if (rx_t[1] - rx_t[0] != 41) begin fails++; $display("FAIL b2b_spacing got %0d want 41", rx_t[1] - rx_t[0]); end
    end
    idle_cycles(10);
    tests++; if (status !== 8'h01) begin fails++; $display("FAIL b2b_end_status got %h want 01", status); end
  endtask

  task automatic test_overflow;
    int n;
    logic [7:0] exp [5];
    exp = '{8'h55, 8'h01, 8'h02, 8'h03, 8'h04};
    rx_q.delete(); rx_t.delete();
    do_store(8'hFD, 8'h55);
    @(negedge clk);
    for (int i = 1; i <= 5; i++) do_store(8'hFD, 8'(i));
    tests++; if (status !== 8'h0E) begin fails++; $display("FAIL ovf_status got %h want 0E", status); end
    do_store(8'hFC, 8'hFF);
    tests++; if (status !== 8'h06) begin fails++; $display("FAIL ovf_clear got %h want 06", status); end
    n = 0;
    while (rx_q.size() < 5 && n < 300) begin @(negedge clk); n++; end
    idle_cycles(60);
    tests++; if (rx_q.size() != 5) begin fails++; $display("FAIL ovf_count got %0d want 5", rx_q.size()); end
    else begin
      for (int i = 0; i < 5; i++) begin
        tests++; if (rx_q[i] !== exp[i]) begin fails++; $display("FAIL ovf_byte%0d got %h want %h", i, rx_q[i], exp[i]); end
      end
    end
    tests++; if (status !== 8'h01) begin fails++; $display("FAIL ovf_end_status got %h want 01", status); end
  endtask

  task automatic test_wrap;
    int n;
    rx_q.delete(); rx_t.delete();
    do_store(8'hFD, 8'h10);
    @(negedge clk);
    for (int k = 1; k <= 4; k++) do_store(8'hFD, 8'h10 + 8'(k));
    tests++; if (status !== 8'h06) begin fails++; $display("FAIL wrap_full got %h want 06", status); end
    for (int k = 5; k <= 8; k++) begin
      n = 0;
      while (status[2] !== 1'b0 && n < 100) begin @(negedge clk); n++; end
      tests++; if (status[2] !== 1'b0) begin fails++; $display("FAIL wrap_idle_wait%0d got busy want idle", k); end
      do_store(8'hFD, 8'h10 + 8'(k));
      tests++; if (status !== 8'h06) begin fails++; $display("FAIL wrap_pushpop%0d got %h want 06", k, status); end
    end
    n = 0;
    while (rx_q.size() < 9 && n < 600) begin @(negedge clk); n++; end
    idle_cycles(10);
    tests++; if (rx_q.size() != 9) begin fails++; $display("FAIL wrap_count got %0d want 9", rx_q.size()); end
    else begin
      for (int k = 0; k < 9; k++) begin
        tests++; if (rx_q[k] !== 8'h10 + 8'(k)) begin fails++; $display("FAIL wrap_byte%0d got %h want %h", k, rx_q[k], 8'h10 + 8'(k)); end
      end
    end
    tests++; if (status !== 8'h01) begin fails++; $display("FAIL wrap_end_status got %h want 01", status); end
  endtask

  task automatic test_reset_midframe;
    int lows;
    rx_q.delete(); rx_t.delete();
    do_store(8'hFD, 8'h3C);
    do_store(8'hFD, 8'h11);
    do_store(8'hFD, 8'h22);
    // The frame started one negedge ago. Advance into the cycles of data bit 3.
    idle_cycles(16);
    rst = 1'b1;
    @(negedge clk);
    tests++; if (tx !== 1'b1) begin fails++; $display("FAIL rstmid_tx got %b want 1", tx); end
    tests++; if (status !== 8'h01) begin fails++; $display("FAIL rstmid_status got %h want 01", status); end
    rst = 1'b0;
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    tests++; if (lows != 0) begin fails++; $display("FAIL rstmid_line got %0d low cycles want 0", lows); end
    tests++; if (rx_q.size() != 0) begin fails++; $display("FAIL rstmid_frames got %0d want 0", rx_q.size()); end
    tests++; if (status !== 8'h01) begin fails++; $display("FAIL rstmid_end_status got %h want 01", status); end
  endtask

  initial begin
    test_reset();
    test_ignore();
    test_single();
    test_back_to_back();
    test_overflow();
    test_wrap();
    tests++; if (rx_ferr != 0) begin fails++; $display("FAIL stop_bits got %0d errors want 0", rx_ferr); end
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
